// File: rtl/fft_pkg.sv
// Shared defaults, collector FSM state type and the bit-reverse helper for the FFT output collector.
package fft_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefSeqLength = 16;

  // Widest index bitrev() can handle; callers pass their real width.
  localparam int unsigned MaxAddrW    = 16;
  localparam int unsigned MaxAddrIdxW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDrain
  } coll_state_e;

  // Reverses the low 'width' bits of val; bits at and above 'width' come back as zero.
  function automatic logic [MaxAddrW-1:0] bitrev(input logic [MaxAddrW-1:0] val,
                                                 input int unsigned        width);
    logic [MaxAddrW-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MaxAddrW; i++) begin
      if (i < width) begin
        res[MaxAddrIdxW'(i)] = val[MaxAddrIdxW'(width - 1 - i)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// Single-frame bin store: one write port, one synchronous read port whose register holds between
// reads and is cleared by reset.
module fft_frame_buffer #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_d, rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_output_collector.sv
// Captures one FFT frame and replays it over valid/ready with a last marker.
// Define FFT_COLLECT_BIT_REVERSE_EN to undo bit-reversed order; otherwise bins pass in arrival order.
module fft_output_collector
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned SEQ_LENGTH = DefSeqLength,
  parameter int unsigned ADDR_W     = $clog2(SEQ_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in_real,
  input  logic [DATA_WIDTH-1:0] data_in_img,
  input  logic                  valid_in,
  input  logic                  done_in,
  output logic [DATA_WIDTH-1:0] data_out_real,
  output logic [DATA_WIDTH-1:0] data_out_img,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(SEQ_LENGTH - 1);

  coll_state_e       state_d, state_q;
  logic [ADDR_W-1:0] wr_cnt_d, wr_cnt_q;
  logic [ADDR_W-1:0] rd_idx_d, rd_idx_q;
  logic              valid_d, valid_q;
  logic              last_d, last_q;
  logic              overflow_d, overflow_q;

  logic                    cap_last, handshake;
  logic                    wr_en, rd_en;
  logic [ADDR_W-1:0]       wr_addr, rd_addr;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign cap_last  = valid_in && (wr_cnt_q == LastIdx);
  assign handshake = valid_q && ready_in;

`ifdef FFT_COLLECT_BIT_REVERSE_EN
  assign wr_addr = ADDR_W'(bitrev(MaxAddrW'(wr_cnt_q), ADDR_W));
`else
  assign wr_addr = wr_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_cnt_q   <= '0;
      rd_idx_q   <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_idx_q   <= rd_idx_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_idx_d   = rd_idx_q;
    valid_d    = valid_q;
    last_d     = last_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          wr_cnt_d = ADDR_W'(1);
          state_d  = StCapture;
        end
      end
      StCapture: begin
        if (done_in && !cap_last) begin
          overflow_d = 1'b1;
        end
        if (valid_in) begin
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end
        if (cap_last) begin
          state_d  = StDrain;
          rd_idx_d = '0;
          valid_d  = 1'b1;
          last_d   = 1'b0;
        end
      end
      StDrain: begin
        // Single buffer: anything arriving while draining is lost.
        if (valid_in) begin
          overflow_d = 1'b1;
        end
        if (handshake) begin
          if (rd_idx_q == LastIdx) begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            rd_idx_d = rd_idx_q + ADDR_W'(1);
            last_d   = (rd_idx_q + ADDR_W'(1)) == LastIdx;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    wr_en   = valid_in && (state_q == StIdle || state_q == StCapture);
    rd_en   = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      StCapture: rd_en = cap_last;
      StDrain: begin
        rd_en   = handshake && (rd_idx_q != LastIdx);
        rd_addr = rd_idx_q + ADDR_W'(1);
      end
      default: rd_en = 1'b0;
    endcase
  end

  // The read-port register doubles as the output data register.
  fft_frame_buffer #(
    .Width(2 * DATA_WIDTH),
    .Depth(SEQ_LENGTH),
    .AddrW(ADDR_W)
  ) u_buf (
    .clk_i    (clk),
    .rst_i    (reset),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i({data_in_real, data_in_img}),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  assign data_out_real = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign data_out_img  = rd_data[DATA_WIDTH-1:0];
  assign valid_out     = valid_q;
  assign last_out      = last_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_fft_output_collector.sv
// Directed self-checking bench for fft_output_collector; expected order follows
// FFT_COLLECT_BIT_REVERSE_EN.
module tb_fft_output_collector;

  localparam int DW = 16;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in_real = '0;
  logic [DW-1:0] data_in_img = '0;
  logic          valid_in = 1'b0;
  logic          done_in = 1'b0;
  logic          ready_in = 1'b0;
  logic [DW-1:0] data_out_real, data_out_img;
  logic          valid_out, last_out, busy, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } obs_t;
  obs_t obs_q[$];

`ifdef FFT_COLLECT_BIT_REVERSE_EN
  int exp_order [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
  int exp_order [N] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

  always #5 clk = ~clk;

  fft_output_collector #(
    .DATA_WIDTH(DW),
    .SEQ_LENGTH(N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in_real (data_in_real),
    .data_in_img  (data_in_img),
    .valid_in     (valid_in),
    .done_in      (done_in),
    .data_out_real(data_out_real),
    .data_out_img (data_out_img),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .last_out     (last_out),
    .busy         (busy),
    .overflow     (overflow)
  );

  // Record every accepted output bin.
  always @(negedge clk) begin
    if (!reset && valid_out && ready_in) obs_q.push_back({data_out_real, data_out_img, last_out});
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_bin(input int val, input logic dn);
    data_in_real = DW'(val);
    data_in_img  = DW'(val + 100);
    valid_in     = 1'b1;
    done_in      = dn;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    done_in  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int gap, input int done_at);
    for (int k = 0; k < N; k++) begin
      put_bin(base + k, k == done_at);
      if (k != N - 1) idle_cycles(gap);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && busy; c++) idle_cycles(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycles(3);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
    checks++; if (last_out !== 1'b0) begin errors++; $display("FAIL reset last_out: got %b want 0", last_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
    checks++; if (data_out_real !== '0 || data_out_img !== '0) begin
      errors++; $display("FAIL reset data: got %0d/%0d want 0/0", data_out_real, data_out_img);
    end
    reset = 1'b0;
  endtask

  task automatic test_reorder();
    obs_t e;
    obs_q.delete();
    ready_in = 1'b1;
    for (int k = 0; k < N - 1; k++) put_bin(k, 1'b0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reorder early valid: got %b want 0", valid_out); end
    put_bin(N - 1, 1'b0);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL reorder latency valid: got %b want 1", valid_out); end
    checks++; if (data_out_real !== DW'(exp_order[0])) begin
      errors++; $display("FAIL reorder first bin: got %0d want %0d", data_out_real, exp_order[0]);
    end
    wait_idle(40);
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL reorder count: got %0d want %0d", obs_q.size(), N); end
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      e = '{re: DW'(exp_order[j]), im: DW'(100 + exp_order[j]), last: (j == N - 1)};
      checks++; if (obs_q[j] !== e) begin
        errors++; $display("FAIL reorder bin %0d: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                           j, obs_q[j].re, obs_q[j].im, obs_q[j].last, e.re, e.im, e.last);
      end
    end
    checks++; if (busy !== 1'b0 || valid_out !== 1'b0) begin
      errors++; $display("FAIL reorder end: got busy=%b valid=%b want 0/0", busy, valid_out);
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reorder overflow: got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    int   pat [4] = '{1, 0, 0, 1};
    logic stall;
    logic [2*DW+1:0] snap;
    obs_t e;
    obs_q.delete();
    ready_in = 1'b0;
    send_frame(200, 0, -1);
    for (int c = 0; c < 120 && busy; c++) begin
      ready_in = (pat[c % 4] != 0);
      stall    = valid_out && !ready_in;
      snap     = {data_out_real, data_out_img, last_out, valid_out};
      idle_cycles(1);
      if (stall) begin
        checks++; if ({data_out_real, data_out_img, last_out, valid_out} !== snap) begin
          errors++; $display("FAIL backpressure hold cycle %0d: got %h want %h", c,
                             {data_out_real, data_out_img, last_out, valid_out}, snap);
        end
      end
    end
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL backpressure count: got %0d want %0d", obs_q.size(), N); end
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      e = '{re: DW'(200 + exp_order[j]), im: DW'(300 + exp_order[j]), last: (j == N - 1)};
      checks++; if (obs_q[j] !== e) begin
        errors++; $display("FAIL backpressure bin %0d: got re=%0d last=%b want re=%0d last=%b",
                           j, obs_q[j].re, obs_q[j].last, e.re, e.last);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL backpressure busy: got %b want 0", busy); end
  endtask

  task automatic test_overflow_drain();
    obs_t e;
    obs_q.delete();
    ready_in = 1'b0;
    send_frame(300, 0, -1);
    put_bin(999, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain overflow: got %b want 1", overflow); end
    ready_in = 1'b1;
    wait_idle(40);
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL drain count: got %0d want %0d", obs_q.size(), N); end
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      e = '{re: DW'(300 + exp_order[j]), im: DW'(400 + exp_order[j]), last: (j == N - 1)};
      checks++; if (obs_q[j] !== e) begin
        errors++; $display("FAIL drain bin %0d: got re=%0d im=%0d want re=%0d im=%0d",
                           j, obs_q[j].re, obs_q[j].im, e.re, e.im);
      end
    end
  endtask

  task automatic test_done_early();
    obs_t e;
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL done reset overflow: got %b want 0", overflow); end
    obs_q.delete();
    ready_in = 1'b1;
    send_frame(400, 0, 7);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL done overflow: got %b want 1", overflow); end
    wait_idle(40);
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL done count: got %0d want %0d", obs_q.size(), N); end
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      e = '{re: DW'(400 + exp_order[j]), im: DW'(500 + exp_order[j]), last: (j == N - 1)};
      checks++; if (obs_q[j] !== e) begin
        errors++; $display("FAIL done bin %0d: got re=%0d want re=%0d", j, obs_q[j].re, e.re);
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    obs_q.delete();
    ready_in = 1'b1;
    for (int k = 0; k < 9; k++) put_bin(500 + k, 1'b0);
    reset = 1'b1;
    idle_cycles(1);
    checks++; if (valid_out !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midreset state: got valid=%b busy=%b ovf=%b want 0/0/0", valid_out, busy, overflow);
    end
    reset = 1'b0;
    send_frame(600, 0, -1);
    wait_idle(40);
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL midreset count: got %0d want %0d", obs_q.size(), N); end
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      e = '{re: DW'(600 + exp_order[j]), im: DW'(700 + exp_order[j]), last: (j == N - 1)};
      checks++; if (obs_q[j] !== e) begin
        errors++; $display("FAIL midreset bin %0d: got re=%0d want re=%0d", j, obs_q[j].re, e.re);
      end
    end
  endtask

  task automatic test_gap_back_to_back();
    obs_t e;
    obs_q.delete();
    ready_in = 1'b1;
    send_frame(700, 1, -1);
    wait_idle(40);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL gap valid drop: got %b want 0", valid_out); end
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL gap count: got %0d want %0d", obs_q.size(), N); end
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      e = '{re: DW'(700 + exp_order[j]), im: DW'(800 + exp_order[j]), last: (j == N - 1)};
      checks++; if (obs_q[j] !== e) begin
        errors++; $display("FAIL gap bin %0d: got re=%0d want re=%0d", j, obs_q[j].re, e.re);
      end
    end
    obs_q.delete();
    send_frame(1000, 0, -1);
    wait_idle(40);
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL b2b count: got %0d want %0d", obs_q.size(), N); end
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      e = '{re: DW'(1000 + exp_order[j]), im: DW'(1100 + exp_order[j]), last: (j == N - 1)};
      checks++; if (obs_q[j] !== e) begin
        errors++; $display("FAIL b2b bin %0d: got re=%0d last=%b want re=%0d last=%b",
                           j, obs_q[j].re, obs_q[j].last, e.re, e.last);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b overflow: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_reorder();
    test_backpressure();
    test_overflow_drain();
    test_done_early();
    test_mid_reset();
    test_gap_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
